// File: rtl/strm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strm_pkg                                                             |
// | Mode encodings and types shared by the strm stream FIFO family.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package strm_pkg;

    typedef logic [1:0] strm_mode_t;

    localparam strm_mode_t MODE_CLR = 2'b00;
    localparam strm_mode_t MODE_SER = 2'b01;
    localparam strm_mode_t MODE_PAR = 2'b10;
    localparam strm_mode_t MODE_CYC = 2'b11;

endpackage
`default_nettype wire

// File: rtl/strm_fifo_multimode_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strm_fifo_multimode_if                                               |
// | Control, data and status bundle of the multimode stream FIFO.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface strm_fifo_multimode_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) ();
    import strm_pkg::*;

    logic              cfg_we;
    strm_mode_t        cfg_mode;
    logic              hold;
    logic              write;
    logic              shift_en;
    logic              serial_in;
    logic [DATA_W-1:0] par_in;
    logic              serial_out;
    logic [DATA_W-1:0] par_out;
    strm_mode_t        mode;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output cfg_we, cfg_mode, hold, write, shift_en, serial_in, par_in,
        input  serial_out, par_out, mode, empty, full, count, overflow, underflow
    );

    modport slave (
        input  cfg_we, cfg_mode, hold, write, shift_en, serial_in, par_in,
        output serial_out, par_out, mode, empty, full, count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/strm_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strm_ram                                                             |
// | DEPTH x DATA_W store: synchronous write, combinational read.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module strm_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    // No reset: contents are only ever invalidated through the pointers.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/strm_fifo_multimode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strm_fifo_multimode                                                  |
// | Stream FIFO with serial, parallel and circular-replay access modes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module strm_fifo_multimode
    import strm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    strm_fifo_multimode_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    strm_mode_t        mode_q,    mode_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  cyc_ptr_q, cyc_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [DATA_W-1:0] in_sr_q,   in_sr_d;
    logic [DATA_W-1:0] out_sr_q,  out_sr_d;
    logic [DATA_W-1:0] par_out_q, par_out_d;
    logic              hold_q,    hold_d;
    logic              ovf_q,     ovf_d;
    logic              udf_q,     udf_d;

    logic              w_strb;
    logic              w_empty;
    logic              w_full;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [PTR_W-1:0]  w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic [PTR_W-1:0]  w_last_ptr;

    assign w_strb     = bus.hold & ~hold_q;
    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == C_FULL_CNT);
    assign w_raddr    = (mode_q == MODE_CYC) ? cyc_ptr_q : rd_ptr_q;
    // Newest valid entry; replay wraps back to the oldest after it.
    assign w_last_ptr = rd_ptr_q + count_q[PTR_W-1:0] - C_PTR_ONE;

    strm_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (wr_ptr_q),
        .i_wdata (w_mem_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        mode_d      = mode_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cyc_ptr_d   = cyc_ptr_q;
        count_d     = count_q;
        in_sr_d     = in_sr_q;
        out_sr_d    = out_sr_q;
        par_out_d   = par_out_q;
        hold_d      = bus.hold;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = (mode_q == MODE_SER) ? in_sr_q : bus.par_in;

        // Shift first so a same-cycle load or clear below overrides it.
        if (bus.shift_en && (mode_q == MODE_SER || mode_q == MODE_CYC)) begin
            in_sr_d  = {in_sr_q[DATA_W-2:0], bus.serial_in};
            out_sr_d = {out_sr_q[DATA_W-2:0], 1'b0};
        end

        if (bus.cfg_we) begin
            mode_d = bus.cfg_mode;
            if (bus.cfg_mode == MODE_CLR) begin
                rd_ptr_d  = '0;
                wr_ptr_d  = '0;
                cyc_ptr_d = '0;
                count_d   = '0;
                out_sr_d  = '0;
                par_out_d = '0;
            end else if (bus.cfg_mode == MODE_CYC) begin
                cyc_ptr_d = rd_ptr_q;
            end
        end else if (w_strb && mode_q != MODE_CLR) begin
            if (bus.write) begin
                if (mode_q != MODE_CYC) begin
                    if (w_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                        count_d  = count_q + C_CNT_ONE;
                    end
                end
            end else if (w_empty) begin
                par_out_d = '0;
                out_sr_d  = '0;
                udf_d     = 1'b1;
            end else begin
                par_out_d = w_rdata;
                out_sr_d  = w_rdata;
                if (mode_q == MODE_CYC) begin
                    cyc_ptr_d = (cyc_ptr_q == w_last_ptr) ? rd_ptr_q : cyc_ptr_q + C_PTR_ONE;
                end else begin
                    rd_ptr_d = rd_ptr_q + C_PTR_ONE;
                    count_d  = count_q - C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= MODE_CLR;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cyc_ptr_q <= '0;
            count_q   <= '0;
            in_sr_q   <= '0;
            out_sr_q  <= '0;
            par_out_q <= '0;
            hold_q    <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cyc_ptr_q <= cyc_ptr_d;
            count_q   <= count_d;
            in_sr_q   <= in_sr_d;
            out_sr_q  <= out_sr_d;
            par_out_q <= par_out_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign bus.serial_out = out_sr_q[DATA_W-1];
    assign bus.par_out    = par_out_q;
    assign bus.mode       = mode_q;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_strm_fifo_multimode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_strm_fifo_multimode                                               |
// | Directed stimulus with a queue-based scoreboard and negedge monitor. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_strm_fifo_multimode;
    import strm_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [7:0] par;
        logic [4:0] cnt;
        logic       ovf;
        logic       udf;
        logic [1:0] mode;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    strm_fifo_multimode_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    strm_fifo_multimode #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q [$];
    logic       ser_q [$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] cur_mode = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: an op (strobe or cfg write) is seen before its edge, checked one cycle later.
    logic pend      = 1'b0;
    logic prev_hold = 1'b1;
    exp_t cur;

    always @(negedge clk) begin
        if (!reset) begin
            pend      = 1'b0;
            prev_hold = 1'b1;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("par_out",   32'(bus.par_out),   32'(cur.par));
                    chk("count",     32'(bus.count),     32'(cur.cnt));
                    chk("overflow",  32'(bus.overflow),  32'(cur.ovf));
                    chk("underflow", 32'(bus.underflow), 32'(cur.udf));
                    chk("mode",      32'(bus.mode),      32'(cur.mode));
                    chk("empty",     32'(bus.empty),     32'(cur.cnt == 5'd0));
                    chk("full",      32'(bus.full),      32'(cur.cnt == 5'd16));
                end
            end else begin
                chk("idle_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
            end
            if (bus.shift_en) begin
                if (ser_q.size() == 0) chk("unexpected_shift", 32'd1, 32'd0);
                else chk("serial_out", 32'(bus.serial_out), 32'(ser_q.pop_front()));
            end
            pend      = bus.cfg_we | (bus.hold & ~prev_hold);
            prev_hold = bus.hold;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] ep, input logic [4:0] ec, input logic eo, input logic eu);
        exp_t e;
        e.par  = ep;
        e.cnt  = ec;
        e.ovf  = eo;
        e.udf  = eu;
        e.mode = cur_mode;
        exp_q.push_back(e);
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic [7:0] ep, input logic [4:0] ec);
        cur_mode = m;
        push_exp(ep, ec, 1'b0, 1'b0);
        bus.cfg_we   = 1'b1;
        bus.cfg_mode = m;
        tick();
        bus.cfg_we = 1'b0;
        tick();
    endtask

    task automatic op(input logic wr, input logic [7:0] d, input logic [7:0] ep,
                      input logic [4:0] ec, input logic eo, input logic eu);
        push_exp(ep, ec, eo, eu);
        bus.write  = wr;
        bus.par_in = d;
        bus.hold   = 1'b1;
        tick();
        bus.hold = 1'b0;
        tick();
    endtask

    // Shifts the low n bits of din MSB first; eout gives serial_out bits before each shift.
    task automatic shift_bits(input logic [7:0] din, input logic [7:0] eout, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser_q.push_back(eout[i]);
            bus.shift_en  = 1'b1;
            bus.serial_in = din[i];
            tick();
        end
        bus.shift_en = 1'b0;
    endtask

    initial begin
        logic [7:0] sw [4];
        logic [7:0] cv [3];
        logic [7:0] prev;
        logic [7:0] v;
        sw[0] = 8'hDE; sw[1] = 8'hAD; sw[2] = 8'hBE; sw[3] = 8'hEF;
        cv[0] = 8'h87; cv[1] = 8'h65; cv[2] = 8'h43;

        bus.cfg_we = 1'b0; bus.cfg_mode = 2'b00; bus.hold = 1'b0; bus.write = 1'b0;
        bus.shift_en = 1'b0; bus.serial_in = 1'b0; bus.par_in = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        chk("rst_par_out",    32'(bus.par_out),    32'd0);
        chk("rst_count",      32'(bus.count),      32'd0);
        chk("rst_empty",      32'(bus.empty),      32'd1);
        chk("rst_full",       32'(bus.full),       32'd0);
        chk("rst_serial_out", 32'(bus.serial_out), 32'd0);
        chk("rst_mode",       32'(bus.mode),       32'd0);
        @(posedge clk); #1;

        // Serial round trip
        do_cfg(2'b01, 8'h00, 5'd0);
        shift_bits(8'hAA, 8'h00, 8);
        op(1'b1, 8'h00, 8'h00, 5'd1, 1'b0, 1'b0);
        op(1'b0, 8'h00, 8'hAA, 5'd0, 1'b0, 1'b0);
        shift_bits(8'h00, 8'hAA, 8);

        // Serial ordering and underflow
        for (int i = 0; i < 4; i++) begin
            shift_bits(sw[i], 8'h00, 8);
            op(1'b1, 8'h00, 8'hAA, 5'(i + 1), 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) op(1'b0, 8'h00, sw[i], 5'(3 - i), 1'b0, 1'b0);
        repeat (4) op(1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);

        // Parallel fill, overflow, drain
        do_cfg(2'b10, 8'h00, 5'd0);
        for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 8'h00, 5'(i + 1), 1'b0, 1'b0);
        op(1'b1, 8'h87, 8'h00, 5'd16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 8'(i), 5'(15 - i), 1'b0, 1'b0);

        // Cycle replay
        for (int i = 0; i < 3; i++) op(1'b1, cv[i], 8'h0F, 5'(i + 1), 1'b0, 1'b0);
        do_cfg(2'b11, 8'h0F, 5'd3);
        for (int i = 0; i < 7; i++) op(1'b0, 8'h00, cv[i % 3], 5'd3, 1'b0, 1'b0);
        op(1'b1, 8'h21, 8'h87, 5'd3, 1'b0, 1'b0);

        // Pointer wrap with alternating push/pop
        do_cfg(2'b10, 8'h87, 5'd3);
        for (int i = 0; i < 3; i++) op(1'b0, 8'h00, cv[i], 5'(2 - i), 1'b0, 1'b0);
        prev = 8'h43;
        for (int i = 0; i < 20; i++) begin
            v = 8'(i * 13 + 5);
            op(1'b1, v, prev, 5'd1, 1'b0, 1'b0);
            op(1'b0, 8'h00, v, 5'd0, 1'b0, 1'b0);
            prev = v;
        end

        // Clear config beats a coincident pop strobe
        op(1'b1, 8'h11, prev, 5'd1, 1'b0, 1'b0);
        op(1'b1, 8'h22, prev, 5'd2, 1'b0, 1'b0);
        cur_mode = 2'b00;
        push_exp(8'h00, 5'd0, 1'b0, 1'b0);
        bus.cfg_we = 1'b1; bus.cfg_mode = 2'b00; bus.write = 1'b0; bus.hold = 1'b1;
        tick();
        bus.cfg_we = 1'b0; bus.hold = 1'b0;
        tick();
        do_cfg(2'b10, 8'h00, 5'd0);
        op(1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);

        // Reset in the middle of a serial shift
        do_cfg(2'b01, 8'h00, 5'd0);
        shift_bits(8'h07, 8'h00, 3);
        bus.shift_en = 1'b1; bus.serial_in = 1'b1; reset = 1'b0;
        tick();
        bus.shift_en = 1'b0; reset = 1'b1;
        cur_mode = 2'b00;
        @(negedge clk);
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_count", 32'(bus.count), 32'd0);
        @(posedge clk); #1;
        do_cfg(2'b01, 8'h00, 5'd0);
        op(1'b1, 8'h00, 8'h00, 5'd1, 1'b0, 1'b0);
        op(1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);

        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("ser_q_drained", 32'(ser_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
